// File: rtl/bcd_tens_display_fsm_if.sv
// bcd_tens_display_fsm_if: units-counter input and two-digit display output bundle.
interface bcd_tens_display_fsm_if;
  logic [3:0] units;
  logic       load;
  logic [3:0] tens;
  logic       wrap;
  logic [6:0] seg;
  logic [1:0] an;
  modport master (output units, load, input tens, wrap, seg, an);
  modport slave  (input units, load, output tens, wrap, seg, an);
endinterface

// File: rtl/bcd_tens_display_fsm.sv
// bcd_tens_display_fsm: derives a tens digit from units wrap-arounds and scans both digits onto a 7-segment display.
module bcd_tens_display_fsm #(
  parameter int SCAN_DIV = 4,
  parameter int TENS_MAX = 9
) (
  input logic                          clk,
  input logic                          res,
  bcd_tens_display_fsm_if.slave        bus
);
  typedef enum logic {SHOW_U, SHOW_T} state_t;
  localparam logic [3:0] TMAX = 4'(TENS_MAX);
  localparam logic [7:0] CMAX = 8'(SCAN_DIV - 1);
  state_t     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_units_q, r_tens, w_tens_nxt;
  logic       r_wrap, w_wrap_nxt;
  logic [6:0] r_seg, w_seg_nxt;
  logic [1:0] r_an, w_an_nxt;
  logic       w_carry, w_borrow, w_done;
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction
  // Only an exact 9<->0 step of an unloaded counter moves the tens digit.
  always_comb begin
    w_carry    = !bus.load && r_units_q == 4'd9 && bus.units == 4'd0;
    w_borrow   = !bus.load && r_units_q == 4'd0 && bus.units == 4'd9;
    w_tens_nxt = w_carry  ? ((r_tens == TMAX) ? 4'd0 : r_tens + 4'd1) :
                 w_borrow ? ((r_tens == 4'd0) ? TMAX : r_tens - 4'd1) : r_tens;
    w_wrap_nxt = r_wrap | (w_carry && r_tens == TMAX) | (w_borrow && r_tens == 4'd0);
  end
  always_comb begin
    w_done      = r_cnt == CMAX;
    w_state_nxt = w_done ? ((r_state == SHOW_U) ? SHOW_T : SHOW_U) : r_state;
    w_cnt_nxt   = w_done ? 8'd0 : r_cnt + 8'd1;
    w_an_nxt    = (r_state == SHOW_U) ? 2'b10 : 2'b01;
    w_seg_nxt   = decode((r_state == SHOW_U) ? r_units_q : r_tens);
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= SHOW_U;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_units_q <= 4'd0;
      r_tens    <= 4'd0;
      r_wrap    <= 1'b0;
      r_seg     <= 7'b0111111;
      r_an      <= 2'b10;
    end else begin
      r_units_q <= bus.units;
      r_tens    <= w_tens_nxt;
      r_wrap    <= w_wrap_nxt;
      r_seg     <= w_seg_nxt;
      r_an      <= w_an_nxt;
    end
  end
  assign bus.tens = r_tens;
  assign bus.wrap = r_wrap;
  assign bus.seg  = r_seg;
  assign bus.an   = r_an;
endmodule
